// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM that sequences a multicycle RV32I-subset
// datapath (shared instr/data memory, IR, OldPC, ALUOut and Data registers).
//
// state    | meaning
// FETCH    | read instruction at PC; on mem_ready load IR/OldPC and PC <- PC+4
// DECODE   | ALUOut <- OldPC + imm (branch/jump target), dispatch on op
// MEMADR   | ALUOut <- rs1 + imm (effective address)
// MEMREAD  | load access at ALUOut, wait for mem_ready
// MEMWB    | rd <- Data
// MEMWRITE | store access at ALUOut, strobe only with mem_ready
// EXECR    | ALUOut <- rs1 op rs2
// ALUWB    | rd <- ALUOut
// EXECI    | ALUOut <- rs1 op imm
// JAL      | PC <- ALUOut (target), ALUOut <- OldPC + 4
// BEQ      | rs1 - rs2, PC <- ALUOut when Zero
// TRAP     | illegal opcode/funct3 or memory timeout; held until reset
module multicycle_controller #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       trap,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Timeout fires on the cycle the counter already holds WAIT_LIMIT-1 and the
  // memory is still not ready, i.e. after exactly WAIT_LIMIT waiting cycles.
  localparam bit         TIMEOUT_EN = (WAIT_LIMIT != 0);
  localparam logic [7:0] WAIT_LAST  = 8'(WAIT_LIMIT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       wait_expired;
  logic       alu_ok;
  logic [2:0] alu_ctl;

  logic       mem_req_c;
  logic       ir_write_c;
  logic       pc_write_c;
  logic       mem_write_c;
  logic       reg_write_c;

  // Counter saturates so an unbounded wait never wraps back to a small value.
  assign wait_inc     = (wait_cnt == 8'hff) ? wait_cnt : wait_cnt + 8'd1;
  assign wait_expired = TIMEOUT_EN && (wait_cnt == WAIT_LAST);

  // ALU operation from funct3; unsupported encodings mark the instruction illegal.
  always_comb begin
    alu_ok  = 1'b1;
    alu_ctl = ALU_ADD;
    case (funct3)
      3'b000:  alu_ctl = (state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_ctl = ALU_SLT;
      3'b110:  alu_ctl = ALU_OR;
      3'b111:  alu_ctl = ALU_AND;
      default: alu_ok  = 1'b0;
    endcase
  end

  // State register and memory wait counter; counter clears whenever the state changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_FETCH, S_MEMREAD, S_MEMWRITE: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            case (state)
              S_FETCH:   state <= S_DECODE;
              S_MEMREAD: state <= S_MEMWB;
              default:   state <= S_FETCH;
            endcase
          end else if (wait_expired) begin
            state    <= S_TRAP;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECR;
            OP_I:         state <= S_EXECI;
            OP_BEQ:       state <= S_BEQ;
            OP_JAL:       state <= S_JAL;
            default:      state <= S_TRAP;
          endcase
        end
        S_MEMADR:           state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_EXECR, S_EXECI:   state <= alu_ok ? S_ALUWB : S_TRAP;
        S_JAL:              state <= S_ALUWB;
        S_MEMWB, S_ALUWB,
        S_BEQ:              state <= S_FETCH;
        S_TRAP:             state <= S_TRAP;
        default:            state <= S_TRAP;
      endcase
    end
  end

  // Per-state datapath controls; strobes gated by mem_ready/Zero where the access completes.
  always_comb begin
    mem_req_c   = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ImmSrc      = 2'b00;
    ALUControl  = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_SW:   ImmSrc = 2'b01;
          OP_BEQ:  ImmSrc = 2'b10;
          OP_JAL:  ImmSrc = 2'b11;
          default: ImmSrc = 2'b00;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_SW) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_c = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = alu_ok ? alu_ctl : ALU_ADD;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_ok ? alu_ctl : ALU_ADD;
      end
      S_ALUWB: begin
        ResultSrc   = 2'b00;
        reg_write_c = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_SUB;
        ImmSrc     = 2'b10;
        pc_write_c = Zero;
      end
      default: ;
    endcase
  end

  // Reset low suppresses every strobe, even while the state reads FETCH.
  assign mem_req  = mem_req_c   & reset;
  assign IRWrite  = ir_write_c  & reset;
  assign PCWrite  = pc_write_c  & reset;
  assign MemWrite = mem_write_c & reset;
  assign RegWrite = reg_write_c & reset;

  assign trap    = (state == S_TRAP);
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level reference model pushes the
// expected strobe events; an independent monitor pops and compares them.
module tb_multicycle_controller;

  localparam int WAIT_LIMIT = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum int {K_ALUI, K_ALUR, K_LW, K_SW, K_BEQ, K_JAL, K_BAD} kind_t;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  st;
    logic        irw;
    logic        pcw;
    logic        mw;
    logic        rw;
    logic [1:0]  rsrc;
    logic        adr;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  int unsigned cyc = 0;
  int unsigned memreq_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  ev_t         evq[$];
  ev_t         mon_e;

  multicycle_controller #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .trap(trap), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (mem_req === 1'b1) memreq_cnt <= memreq_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe cycle must match the next expected event.
  always @(negedge clk) begin
    if ((IRWrite | PCWrite | MemWrite | RegWrite) !== 1'b0) begin
      if (evq.size() == 0) begin
        check("unexpected_strobe", {28'd0, IRWrite, PCWrite, MemWrite, RegWrite}, 32'd0);
      end else begin
        mon_e = evq.pop_front();
        check("ev_cycle", cyc, mon_e.cyc);
        check("ev_state", {28'd0, state_o}, {28'd0, mon_e.st});
        check("ev_strobes", {28'd0, IRWrite, PCWrite, MemWrite, RegWrite},
              {28'd0, mon_e.irw, mon_e.pcw, mon_e.mw, mon_e.rw});
        check("ev_resultsrc", {30'd0, ResultSrc}, {30'd0, mon_e.rsrc});
        check("ev_adrsrc", {31'd0, AdrSrc}, {31'd0, mon_e.adr});
      end
    end
  end

  function automatic logic [2:0] alu_exp(input bit is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit f3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic [1:0] imm_exp(input logic [6:0] o);
    case (o)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic expect_ev(input logic [3:0] st, input logic irw, input logic pcw,
                           input logic mw, input logic rw, input logic [1:0] rs, input logic adr);
    ev_t e;
    e.cyc = cyc; e.st = st; e.irw = irw; e.pcw = pcw; e.mw = mw; e.rw = rw;
    e.rsrc = rs; e.adr = adr;
    evq.push_back(e);
  endtask

  // One clock cycle with the given mem_ready; returns at posedge+1.
  task automatic step(input logic rdy);
    mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic step_rand();
    step(1'($urandom_range(0, 1)));
  endtask

  // A memory access with wt idle cycles before ready; wt >= WAIT_LIMIT times out.
  task automatic do_access(input int wt, input logic [3:0] st, input bit store, output bit tr);
    int unsigned c0;
    c0 = memreq_cnt;
    tr = (wt >= WAIT_LIMIT);
    for (int i = 0; i < wt && i < WAIT_LIMIT; i++) step(1'b0);
    if (!tr) begin
      if (st == 4'd0) expect_ev(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
      else if (store) expect_ev(4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
      step(1'b1);
    end
    check("mem_req_cycles", memreq_cnt - c0, tr ? WAIT_LIMIT : wt + 1);
  endtask

  task automatic trap_and_reset(input int hold);
    check("trap_state", {28'd0, state_o}, 32'd11);
    check("trap_flag", {31'd0, trap}, 32'd1);
    for (int i = 0; i < hold; i++) step_rand();
    check("trap_sticky", {31'd0, trap}, 32'd1);
    mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_state", {28'd0, state_o}, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_strobes", {27'd0, mem_req, IRWrite, PCWrite, MemWrite, RegWrite}, 32'd0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    reset = 1'b1;
  endtask

  // Runs one instruction from FETCH; cycle total follows the per-class phase count.
  task automatic run_instr(input kind_t kind, input logic [2:0] f3, input logic f7,
                           input logic z, input int wf, input int wm, input int hold);
    bit          tr;
    int unsigned c0;
    int unsigned n_exp;
    c0 = cyc;
    case (kind)
      K_ALUI:  op = OP_I;
      K_ALUR:  op = OP_R;
      K_LW:    op = OP_LW;
      K_SW:    op = OP_SW;
      K_BEQ:   op = OP_BEQ;
      K_JAL:   op = OP_JAL;
      default: begin
        op = 7'($urandom_range(0, 127));
        if (op == OP_I || op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_JAL)
          op = 7'b0000000;
      end
    endcase
    funct3 = f3; funct7b5 = f7; Zero = z;
    do_access(wf, 4'd0, 1'b0, tr);
    n_exp = wf + 1;
    if (!tr) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check("decode_state", {28'd0, state_o}, 32'd1);
      check("decode_immsrc", {30'd0, ImmSrc}, {30'd0, imm_exp(op)});
      @(posedge clk);
      #1;
      n_exp += 1;
      case (kind)
        K_LW, K_SW: begin
          step_rand();
          do_access(wm, 4'd3, kind == K_SW, tr);
          n_exp += 1 + wm + 1;
          if (!tr && kind == K_LW) begin
            expect_ev(4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
            step_rand();
            n_exp += 1;
          end
        end
        K_ALUR, K_ALUI: begin
          mem_ready = 1'($urandom_range(0, 1));
          #1;
          if (f3_legal(f3))
            check("alu_control", {29'd0, ALUControl}, {29'd0, alu_exp(kind == K_ALUR, f3, f7)});
          check("alu_srcb", {30'd0, ALUSrcB}, (kind == K_ALUR) ? 32'd0 : 32'd1);
          @(posedge clk);
          #1;
          if (f3_legal(f3)) begin
            expect_ev(4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
            step_rand();
            n_exp += 2;
          end else begin
            tr = 1'b1;
          end
        end
        K_BEQ: begin
          if (z) expect_ev(4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
          step_rand();
          n_exp += 1;
        end
        K_JAL: begin
          expect_ev(4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
          step_rand();
          expect_ev(4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
          step_rand();
          n_exp += 2;
        end
        default: tr = 1'b1;
      endcase
    end
    if (tr) begin
      trap_and_reset(hold);
    end else begin
      check("instr_cycles", cyc - c0, n_exp);
      check("back_to_fetch", {28'd0, state_o}, 32'd0);
    end
  endtask

  task automatic reset_mid_access();
    bit tr;
    op = OP_LW;
    do_access(0, 4'd0, 1'b0, tr);
    step_rand();
    step_rand();
    step(1'b0);
    step(1'b0);
    mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("midrst_state", {28'd0, state_o}, 32'd0);
    check("midrst_strobes", {27'd0, mem_req, IRWrite, PCWrite, MemWrite, RegWrite}, 32'd0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    kind_t k;
    int    r;
    int    wf;
    int    wm;
    logic [2:0] f3;
    mem_ready = 1'b1;
    #1;
    check("reset_state", {28'd0, state_o}, 32'd0);
    check("reset_trap", {31'd0, trap}, 32'd0);
    check("reset_strobes", {27'd0, mem_req, IRWrite, PCWrite, MemWrite, RegWrite}, 32'd0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(K_ALUI, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr(K_LW,   3'b010, 1'b0, 1'b0, 0, 3, 0);
    run_instr(K_BEQ,  3'b000, 1'b0, 1'b1, 1, 0, 0);
    run_instr(K_BEQ,  3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr(K_SW,   3'b010, 1'b0, 1'b0, 2, 2, 0);
    run_instr(K_ALUR, 3'b000, 1'b1, 1'b0, 0, 0, 0);
    run_instr(K_JAL,  3'b000, 1'b0, 1'b0, 0, 0, 0);
    op = 7'b0000000;
    run_instr(K_BAD,  3'b000, 1'b0, 1'b0, 0, 0, 20);
    run_instr(K_ALUI, 3'b000, 1'b0, 1'b0, 9, 0, 5);
    run_instr(K_ALUR, 3'b001, 1'b0, 1'b0, 0, 0, 3);
    run_instr(K_LW,   3'b010, 1'b0, 1'b0, 0, 7, 3);
    reset_mid_access();
    run_instr(K_LW,   3'b010, 1'b0, 1'b0, 0, 3, 0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 18)      k = K_ALUI;
      else if (r < 36) k = K_ALUR;
      else if (r < 52) k = K_LW;
      else if (r < 68) k = K_SW;
      else if (r < 82) k = K_BEQ;
      else if (r < 95) k = K_JAL;
      else             k = K_BAD;
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b010;
        2: f3 = 3'b110;
        3: f3 = 3'b111;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      wf = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      run_instr(k, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wf, wm,
                $urandom_range(1, 5));
    end

    step(1'b0);
    check("queue_drained", evq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
